load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/load_extend.sv | 41 ++++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Holds the FSM state enum, access-size codes and lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_RSVD = 2'b11;

  function automatic logic size_legal(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic ok;
    unique case (size)
      MEM_BYTE: ok = 1'b1;
      MEM_HALF: ok = ~off[0];
      MEM_WORD: ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    unique case (size)
      MEM_BYTE: be = 4'b0001 << off;
      MEM_HALF: be = 4'b0011 << {off[1], 1'b0};
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] d;
    unique case (size)
      MEM_BYTE: d = {4{data[7:0]}};
      MEM_HALF: d = {2{data[15:0]}};
      default:  d = data;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane selection: picks the addressed byte/half of the read
// word and sign- or zero-extends it to 32 bits.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bsign;
  logic        w_hsign;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_bsign = ~i_unsigned & w_byte[7];
  assign w_hsign = ~i_unsigned & w_half[15];

  always_comb begin
    o_result = i_rdata;
    unique case (i_size)
      MEM_BYTE: o_result = {{24{w_bsign}}, w_byte};
      MEM_HALF: o_result = {{16{w_hsign}}, w_half};
      default:  o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding data-bus transaction,
// stalls the pipeline until the access completes.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memReqM,
  input  logic        memWriteM,
  input  logic [1:0]  memSizeM,
  input  logic        memUnsignedM,
  input  logic [31:0] addrM,
  input  logic [31:0] writeDataM,
  output logic        dReqValid,
  input  logic        dReqReady,
  output logic [31:0] dAddr,
  output logic        dWrite,
  output logic [3:0]  dByteEn,
  output logic [31:0] dWData,
  input  logic        dRespValid,
  input  logic [31:0] dRData,
  output logic        stallM,
  output logic [31:0] readDataM,
  output logic        misalignM
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;

  logic        w_legal;
  logic        w_go;
  logic        w_capture;
  logic        w_resp;
  logic [31:0] w_ext;

  logic [31:0] r_addr;
  logic        r_write;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_rdata;

  assign w_legal   = size_legal(memSizeM, addrM[1:0]);
  assign w_go      = memReqM & w_legal;
  assign w_capture = (r_state == S_IDLE) & w_go;
  assign w_resp    = (r_state == S_WAIT) & dRespValid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_REQ;
      S_REQ: begin
        if (dReqReady) w_next = r_write ? S_DONE : S_WAIT;
      end
      S_WAIT: if (dRespValid) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall/misalign are gated by rst so nothing leaks out during reset
  always_comb begin
    dReqValid = ~rst & (r_state == S_REQ);
    stallM    = ~rst & w_go & (r_state != S_DONE);
    misalignM = ~rst & memReqM & ~w_legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
    end else if (w_capture) begin
      r_addr     <= addrM;
      r_write    <= memWriteM;
      r_be       <= byte_en(memSizeM, addrM[1:0]);
      r_wdata    <= lane_data(memSizeM, writeDataM);
      r_size     <= memSizeM;
      r_unsigned <= memUnsignedM;
    end
  end

  load_extend u_ext (
    .i_rdata    (dRData),
    .i_addr     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst)         r_rdata <= '0;
    else if (w_resp) r_rdata <= w_ext;
  end

  assign dAddr     = {r_addr[31:2], 2'b00};
  assign dWrite    = r_write;
  assign dByteEn   = r_be;
  assign dWData    = r_wdata;
  assign readDataM = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus
// random transactions against a byte-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        memReqM;
  logic        memWriteM;
  logic [1:0]  memSizeM;
  logic        memUnsignedM;
  logic [31:0] addrM;
  logic [31:0] writeDataM;
  logic        dReqValid;
  logic        dReqReady;
  logic [31:0] dAddr;
  logic        dWrite;
  logic [3:0]  dByteEn;
  logic [31:0] dWData;
  logic        dRespValid;
  logic [31:0] dRData;
  logic        stallM;
  logic [31:0] readDataM;
  logic        misalignM;

  int          checks;
  int          failures;
  logic [31:0] last_load;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .memReqM      (memReqM),
    .memWriteM    (memWriteM),
    .memSizeM     (memSizeM),
    .memUnsignedM (memUnsignedM),
    .addrM        (addrM),
    .writeDataM   (writeDataM),
    .dReqValid    (dReqValid),
    .dReqReady    (dReqReady),
    .dAddr        (dAddr),
    .dWrite       (dWrite),
    .dByteEn      (dByteEn),
    .dWData       (dWData),
    .dRespValid   (dRespValid),
    .dRData       (dRData),
    .stallM       (stallM),
    .readDataM    (readDataM),
    .misalignM    (misalignM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, alignment by modulo.
  function automatic int m_n(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input logic [1:0] sz,
                                 input logic [31:0] a);
    if (sz == 2'd3) return 1'b0;
    return (a % m_n(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz,
                                      input logic [31:0] a);
    logic [3:0] be;
    int off;
    off = int'(a[1:0]);
    for (int k = 0; k < 4; k++)
      be[k] = (k >= off) && (k < off + m_n(sz));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                          input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = m_n(sz);
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd,
                                         input logic [31:0] a,
                                         input logic [1:0] sz,
                                         input bit uns);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = m_n(sz);
    if (n == 4) return rd;
    v = rd >> (8 * int'(a[1:0]));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    memReqM    = 1'b0;
    dReqReady  = 1'($urandom_range(0, 1));
    dRespValid = 1'($urandom_range(0, 1));
    dRData     = $urandom;
    @(negedge clk);
    chk("idle_stall", 32'(stallM), 32'd0);
    chk("idle_valid", 32'(dReqValid), 32'd0);
    chk("idle_rdata", readDataM, last_load);
  endtask

  task automatic do_txn(input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit uns, input logic [31:0] rd,
                        input int rdly, input int pdly);
    bit lg;
    lg = m_legal(sz, a);
    @(posedge clk); #1;
    memReqM      = 1'b1;
    memWriteM    = wr;
    memSizeM     = sz;
    memUnsignedM = uns;
    addrM        = a;
    writeDataM   = wd;
    dReqReady    = 1'($urandom_range(0, 1));
    dRespValid   = 1'($urandom_range(0, 1));
    dRData       = $urandom;
    @(negedge clk);
    chk("first_misalign", 32'(misalignM), 32'(!lg));
    chk("first_stall", 32'(stallM), 32'(lg));
    chk("first_valid", 32'(dReqValid), 32'd0);
    if (!lg) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("illegal_valid", 32'(dReqValid), 32'd0);
      chk("illegal_stall", 32'(stallM), 32'd0);
      chk("illegal_rdata", readDataM, last_load);
      idle_cycle();
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      @(posedge clk); #1;
      dReqReady  = (i == rdly);
      dRespValid = 1'($urandom_range(0, 1));
      dRData     = $urandom;
      @(negedge clk);
      chk("req_valid", 32'(dReqValid), 32'd1);
      chk("req_addr", dAddr, {a[31:2], 2'b00});
      chk("req_write", 32'(dWrite), 32'(wr));
      chk("req_be", 32'(dByteEn), 32'(m_be(sz, a)));
      chk("req_wdata", dWData, m_wdata(sz, wd));
      chk("req_stall", 32'(stallM), 32'd1);
    end
    @(posedge clk); #1;
    dReqReady  = 1'b0;
    dRespValid = 1'b0;
    if (!wr) begin
      for (int i = 0; i <= pdly; i++) begin
        dRespValid = (i == pdly);
        dRData     = (i == pdly) ? rd : $urandom;
        @(negedge clk);
        chk("wait_stall", 32'(stallM), 32'd1);
        chk("wait_valid", 32'(dReqValid), 32'd0);
        @(posedge clk); #1;
      end
      last_load = m_load(rd, a, sz, uns);
    end
    dRespValid = 1'($urandom_range(0, 1));
    dRData     = $urandom;
    @(negedge clk);
    chk("done_stall", 32'(stallM), 32'd0);
    chk("done_valid", 32'(dReqValid), 32'd0);
    chk("done_rdata", readDataM, last_load);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    last_load    = '0;
    rst          = 1'b1;
    memReqM      = 1'b1;
    memWriteM    = 1'b0;
    memSizeM     = 2'b10;
    memUnsignedM = 1'b0;
    addrM        = 32'h101;
    writeDataM   = 32'h5A5A5A5A;
    dReqReady    = 1'b1;
    dRespValid   = 1'b1;
    dRData       = 32'hFFFFFFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(dReqValid), 32'd0);
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_misalign", 32'(misalignM), 32'd0);
    chk("rst_rdata", readDataM, 32'd0);
    chk("rst_addr", dAddr, 32'd0);
    chk("rst_be", 32'(dByteEn), 32'd0);
    chk("rst_wdata", dWData, 32'd0);
    chk("rst_write", 32'(dWrite), 32'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    memReqM = 1'b0;
    idle_cycle();

    do_txn(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 0, 0);
    do_txn(1'b0, 2'b00, 32'h103, 32'h0, 1'b0, 32'h80FF0000, 0, 0);
    chk("lb_signed", readDataM, 32'hFFFFFF80);
    do_txn(1'b0, 2'b00, 32'h103, 32'h0, 1'b1, 32'h80FF0000, 0, 0);
    chk("lbu_unsigned", readDataM, 32'h00000080);
    do_txn(1'b1, 2'b01, 32'h202, 32'h00001234, 1'b0, 32'h0, 3, 0);
    do_txn(1'b0, 2'b10, 32'h101, 32'h0, 1'b0, 32'h0, 0, 0);
    do_txn(1'b0, 2'b11, 32'h100, 32'h0, 1'b0, 32'h0, 0, 0);
    do_txn(1'b0, 2'b01, 32'h203, 32'h0, 1'b0, 32'h0, 0, 0);
    do_txn(1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 32'hCAFEF00D, 1, 2);

    // Reset while waiting for a load response
    @(posedge clk); #1;
    memReqM      = 1'b1;
    memWriteM    = 1'b0;
    memSizeM     = 2'b10;
    addrM        = 32'h80;
    dReqReady    = 1'b0;
    dRespValid   = 1'b0;
    @(posedge clk); #1;
    dReqReady = 1'b1;
    @(posedge clk); #1;
    dReqReady = 1'b0;
    @(negedge clk);
    chk("wait_pre_rst_stall", 32'(stallM), 32'd1);
    @(posedge clk); #1;
    rst     = 1'b1;
    memReqM = 1'b0;
    @(negedge clk);
    chk("rst_wait_valid", 32'(dReqValid), 32'd0);
    @(posedge clk); #1;
    rst        = 1'b0;
    dRespValid = 1'b1;
    dRData     = 32'h12345678;
    last_load  = '0;
    @(negedge clk);
    chk("rst_wait_rdata", readDataM, 32'd0);
    chk("rst_wait_stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    dRespValid = 1'b0;
    @(negedge clk);
    chk("post_rst_rdata", readDataM, 32'd0);
    chk("post_rst_valid", 32'(dReqValid), 32'd0);
    do_txn(1'b1, 2'b00, 32'h7, 32'h000000A5, 1'b0, 32'h0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b11)
        a = a & ~32'(m_n(sz) - 1);
      do_txn(1'($urandom_range(0, 1)), sz, a, $urandom,
             1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
